// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    typedef struct packed {
        logic en_pc;
        logic en_ifid;
        logic flush_ifid;
        logic en_idex;
        logic flush_idex;
        logic en_exmem;
    } ctl_t;

    localparam ctl_t CTL_RUN = '{en_pc: 1'b1, en_ifid: 1'b1, flush_ifid: 1'b0,
                                 en_idex: 1'b1, flush_idex: 1'b0, en_exmem: 1'b1};
    localparam ctl_t CTL_FREEZE = '{en_pc: 1'b0, en_ifid: 1'b0, flush_ifid: 1'b0,
                                    en_idex: 1'b0, flush_idex: 1'b0, en_exmem: 1'b0};
    // Front end held, bubble into ID/EX, back end keeps moving.
    localparam ctl_t CTL_STALL = '{en_pc: 1'b0, en_ifid: 1'b0, flush_ifid: 1'b0,
                                   en_idex: 1'b1, flush_idex: 1'b1, en_exmem: 1'b1};
    localparam ctl_t CTL_SQUASH = '{en_pc: 1'b1, en_ifid: 1'b1, flush_ifid: 1'b1,
                                    en_idex: 1'b1, flush_idex: 1'b1, en_exmem: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: load-use bubbles, branch squash, memory freeze and
// the halt drain/halted/restart sequence, plus bubble/flush counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       rs_adr_id,
    input  logic [2:0]       rt_adr_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic [2:0]       regwrite_adr_ex,
    input  logic             regwrite_ex,
    input  logic             from_main_mem_ex,
    input  logic             branch_taken_ex,
    input  logic             is_halt_ex,
    input  logic             mem_busy,
    input  logic             restart,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             flush_ifid,
    output logic             en_idex,
    output logic             flush_idex,
    output logic             en_exmem,
    output logic             halted,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state, state_nxt;
    logic [3:0] drain_cnt, drain_nxt;
    ctl_t       ctl;
    logic       load_use;
    logic       bubble_inc;
    logic       flush_inc;

    assign load_use = from_main_mem_ex & regwrite_ex &
                      ((use_rs_id & (rs_adr_id == regwrite_adr_ex)) |
                       (use_rt_id & (rt_adr_id == regwrite_adr_ex)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            halted    <= (state_nxt == HALTED);
        end
    end

    always_comb begin
        ctl        = CTL_RUN;
        state_nxt  = state;
        drain_nxt  = drain_cnt;
        bubble_inc = 1'b0;
        flush_inc  = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    ctl = CTL_FREEZE;
                end else if (is_halt_ex) begin
                    ctl       = CTL_STALL;
                    state_nxt = DRAIN;
                    drain_nxt = 4'(DRAIN_CYCLES);
                end else if (branch_taken_ex) begin
                    ctl       = CTL_SQUASH;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    ctl        = CTL_STALL;
                    bubble_inc = 1'b1;
                end
            end
            DRAIN: begin
                ctl = CTL_STALL;
                if (mem_busy) begin
                    ctl.en_exmem = 1'b0;
                end else begin
                    drain_nxt = drain_cnt - 4'd1;
                    if (drain_cnt <= 4'd1)
                        state_nxt = HALTED;
                end
            end
            HALTED: begin
                ctl = CTL_FREEZE;
                if (restart)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign en_pc      = ctl.en_pc;
    assign en_ifid    = ctl.en_ifid;
    assign flush_ifid = ctl.flush_ifid;
    assign en_idex    = ctl.en_idex;
    assign flush_idex = ctl.flush_idex;
    assign en_exmem   = ctl.en_exmem;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
